// File: rtl/aq_djpeg_loader_if.sv
// Memory read bus and decoder word stream of the JPEG stream loader.
// The loader side uses the master modport.
interface aq_djpeg_loader_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic        MemValid;
  logic [31:0] MemData;
  logic [31:0] DataOut;
  logic        DataOutEnable;
  logic        DataOutRead;
  logic        DecodeIdle;

  modport master (
    output MemReq, MemAddr, DataOut, DataOutEnable,
    input  MemAck, MemValid, MemData, DataOutRead, DecodeIdle
  );
  modport slave (
    input  MemReq, MemAddr, DataOut, DataOutEnable,
    output MemAck, MemValid, MemData, DataOutRead, DecodeIdle
  );
endinterface

// File: rtl/aq_djpeg_loader.sv
// JPEG stream loader: fetches words from memory into a fall-through FIFO feeding the decoder.
// Optional stall watchdog enabled by macro AQ_DJPEG_LOADER_WATCHDOG_EN.
module aq_djpeg_loader #(
  parameter int          FIFO_AW = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Abort,
  input  logic [31:0]       StartAddr,
  input  logic [23:0]       ByteLength,
  aq_djpeg_loader_if.master bus,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  state_t             state, state_nx;
  logic [31:0]        addr;
  logic [22:0]        words_left, wl_init;
  logic               seen_run;
  logic [31:0]        fifo_mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               active, kill, push, pop, flush, ack, eoi, wd_hit;

  assign wl_init = 23'((25'(ByteLength) + 25'd3) >> 2);
  assign Busy    = state != IDLE;
  assign Done    = state == DONE;
  assign active  = state == REQ || state == WAIT || state == DRAIN;
  assign kill    = active && (Abort || wd_hit);
  assign eoi     = seen_run && bus.DecodeIdle;
  // only WAIT accepts read data; anything arriving in DONE/IDLE is dropped
  assign push    = state == WAIT && bus.MemValid && !kill;
  assign pop     = bus.DataOutRead && count != '0;
  assign flush   = kill || state == DONE;
  assign ack     = bus.MemReq && bus.MemAck;

  assign bus.MemReq        = state == REQ && count < DEPTH;
  assign bus.MemAddr       = addr;
  assign bus.DataOutEnable = count != '0;
  assign bus.DataOut       = (count != '0) ? fifo_mem[rd_ptr] : '0;

  always_comb begin
    state_nx = state;
    if (kill) state_nx = DONE;
    else begin
      case (state)
        IDLE:    if (Start) state_nx = (ByteLength == '0) ? DONE : REQ;
        REQ:     if (eoi) state_nx = DONE;
                 else if (ack) state_nx = WAIT;
        WAIT:    if (eoi) state_nx = DONE;
                 else if (bus.MemValid) state_nx = (words_left <= 23'd1) ? DRAIN : REQ;
        DRAIN:   if (eoi) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      words_left <= '0;
      seen_run   <= 1'b0;
      Error      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && Start) begin
        addr       <= StartAddr;
        words_left <= wl_init;
        seen_run   <= 1'b0;
        Error      <= ByteLength == '0;
      end else begin
        if (kill) Error <= 1'b1;
        if (ack) addr <= addr + 32'd4;
        if (push && words_left != '0) words_left <= words_left - 23'd1;
        if (active && !bus.DecodeIdle) seen_run <= 1'b1;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // a read is only issued with room in the FIFO, so push never overflows
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.MemData;
  end

`ifdef AQ_DJPEG_LOADER_WATCHDOG_EN
  logic [31:0] wd_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_cnt <= '0;
    else if (!Busy || push || pop || ack) wd_cnt <= '0;
    else wd_cnt <= wd_cnt + 32'd1;
  end
  assign wd_hit = wd_cnt >= TIMEOUT;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_hit = 1'b0;
`endif
endmodule

// File: tb/tb_aq_djpeg_loader.sv
// Directed bench for aq_djpeg_loader: job table plus hand-written abort/reset/stall/full sequences.
module tb_aq_djpeg_loader;
  logic        clk = 1'b0, rst = 1'b0, Start = 1'b0, Abort = 1'b0;
  logic [31:0] StartAddr = '0;
  logic [23:0] ByteLength = '0;
  logic        Busy, Done, Error;

  aq_djpeg_loader_if bus();

  aq_djpeg_loader #(.FIFO_AW(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Abort(Abort), .StartAddr(StartAddr),
    .ByteLength(ByteLength), .bus(bus), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;

  logic mem_on = 1'b1, hold_valid = 1'b0, clr = 1'b0, pop_en = 1'b1, dec_run = 1'b0;
  int   pop_limit = 0;
  logic [31:0] addr_log [256];
  logic [31:0] pop_log  [256];
  int   addr_n = 0, pop_n = 0, done_cnt = 0;
  logic err_at_done = 1'b0;
  int   n_vec = 0, n_bad = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} + 32'h1357;
  endfunction

  // memory: ack one cycle after seeing MemReq, data one cycle after ack
  initial begin : mem_model
    logic        vld_due;
    logic [31:0] ack_addr;
    vld_due = 1'b0; ack_addr = '0;
    bus.MemAck = 1'b0; bus.MemValid = 1'b0; bus.MemData = '0;
    forever begin
      @(negedge clk);
      if (clr) begin addr_n = 0; done_cnt = 0; end
      else if (Done) begin done_cnt++; err_at_done = Error; end
      bus.MemValid = 1'b0;
      if (bus.MemAck) begin
        bus.MemAck = 1'b0; vld_due = 1'b1;
      end else if (mem_on && bus.MemReq && !vld_due) begin
        bus.MemAck = 1'b1; ack_addr = bus.MemAddr;
        if (addr_n < 256) addr_log[addr_n] = bus.MemAddr;
        addr_n++;
      end
      if (vld_due && !hold_valid && !bus.MemAck) begin
        bus.MemValid = 1'b1; bus.MemData = data_of(ack_addr); vld_due = 1'b0;
      end
    end
  end

  // decoder: runs while dec_run, pops up to pop_limit words, then goes idle
  initial begin : dec_model
    bus.DataOutRead = 1'b0; bus.DecodeIdle = 1'b1;
    forever begin
      @(negedge clk);
      bus.DataOutRead = 1'b0;
      if (!dec_run) begin
        pop_n = 0; bus.DecodeIdle = 1'b1;
      end else if (pop_n >= pop_limit) begin
        bus.DecodeIdle = 1'b1;
      end else begin
        bus.DecodeIdle = 1'b0;
        if (pop_en && bus.DataOutEnable) begin
          bus.DataOutRead = 1'b1;
          if (pop_n < 256) pop_log[pop_n] = bus.DataOut;
          pop_n++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (Busy && k < budget) begin cyc(1); k++; end
    chk(name, 32'(Busy), 0);
  endtask

  task automatic wait_addr(input string name, input int n, input int budget);
    int k = 0;
    while (addr_n < n && k < budget) begin cyc(1); k++; end
    chk(name, 32'(addr_n >= n), 1);
  endtask

  task automatic begin_job(input logic [31:0] a, input logic [23:0] len, input int pl, input logic pe);
    clr = 1'b1; dec_run = 1'b0; cyc(1); clr = 1'b0;
    StartAddr = a; ByteLength = len; pop_limit = pl; pop_en = pe; dec_run = 1'b1;
    Start = 1'b1; cyc(1); Start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_memreq"}, 32'(bus.MemReq), 0);
    chk({tag, "_memaddr"}, bus.MemAddr, 0);
    chk({tag, "_enable"}, 32'(bus.DataOutEnable), 0);
    chk({tag, "_dataout"}, bus.DataOut, 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_error"}, 32'(Error), 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [23:0] blen;
    int          pops;
    int          exp_fetch;  // -1: fetch count depends on decoder timing
    logic        exp_err;
  } vec_t;
  vec_t tbl [8];

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_1000, 24'd10,  3,  3, 1'b0};
    tbl[1] = '{32'h0000_2000, 24'd4,   1,  1, 1'b0};
    tbl[2] = '{32'h0000_3000, 24'd1,   1,  1, 1'b0};
    tbl[3] = '{32'hFFFF_FFF8, 24'd16,  4,  4, 1'b0};
    tbl[4] = '{32'h0000_4000, 24'd0,   0,  0, 1'b1};
    tbl[5] = '{32'h0000_5000, 24'd7,   2,  2, 1'b0};
    tbl[6] = '{32'h0000_6000, 24'd20,  5,  5, 1'b0};
    tbl[7] = '{32'h0000_9000, 24'd256, 5, -1, 1'b0};

    cyc(2);
    chk_reset_vals("reset");
    rst = 1'b1; cyc(2);

    for (int i = 0; i < 8; i++) begin
      begin_job(tbl[i].addr, tbl[i].blen, tbl[i].pops, 1'b1);
      chk("busy_after_start", 32'(Busy), 1);
      wait_idle("job_timeout", 3000);
      chk("pop_count", pop_n, tbl[i].pops);
      for (int k = 0; k < tbl[i].pops; k++)
        chk("pop_data", pop_log[k], data_of(tbl[i].addr + 32'(4 * k)));
      if (tbl[i].exp_fetch >= 0) chk("fetch_count", addr_n, tbl[i].exp_fetch);
      for (int k = 0; k < addr_n && k < 256; k++)
        chk("mem_addr", addr_log[k], tbl[i].addr + 32'(4 * k));
      chk("done_pulses", done_cnt, 1);
      chk("err_at_done", 32'(err_at_done), 32'(tbl[i].exp_err));
      chk("error_sticky", 32'(Error), 32'(tbl[i].exp_err));
      cyc(4);
      chk("fifo_empty_after", 32'(bus.DataOutEnable), 0);
      chk("idle_after", 32'(Busy), 0);
    end

    // FIFO fills to 16 with no pops, then refills one cycle after first pop
    begin_job(32'h8000, 24'd256, 64, 1'b0);
    wait_addr("full_wait", 16, 200);
    cyc(3);
    chk("full_fetches", addr_n, 16);
    chk("full_enable", 32'(bus.DataOutEnable), 1);
    chk("full_head", bus.DataOut, data_of(32'h8000));
    for (int k = 0; k < 4; k++) begin
      chk("full_memreq_low", 32'(bus.MemReq), 0);
      cyc(1);
    end
    pop_en = 1'b1;
    cyc(1);
    chk("resume_memreq", 32'(bus.MemReq), 1);
    wait_idle("full_job_timeout", 3000);
    chk("full_pop_count", pop_n, 64);
    for (int k = 0; k < 64; k++)
      chk("full_pop_data", pop_log[k], data_of(32'h8000 + 32'(4 * k)));
    chk("full_fetch_total", addr_n, 64);
    chk("full_done", done_cnt, 1);
    chk("full_error", 32'(Error), 0);

    // abort while a read is outstanding
    begin_job(32'hA000, 24'd64, 100, 1'b0);
    wait_addr("abort_wait", 4, 100);
    hold_valid = 1'b1;
    cyc(2);
    chk("abort_pre_enable", 32'(bus.DataOutEnable), 1);
    Abort = 1'b1; cyc(1); Abort = 1'b0;
    chk("abort_done", 32'(Done), 1);
    chk("abort_error", 32'(Error), 1);
    chk("abort_flush", 32'(bus.DataOutEnable), 0);
    chk("abort_memreq", 32'(bus.MemReq), 0);
    cyc(1);
    chk("abort_done_one_cycle", 32'(Done), 0);
    chk("abort_busy", 32'(Busy), 0);
    hold_valid = 1'b0;
    cyc(4);
    chk("abort_late_valid", 32'(bus.DataOutEnable), 0);
    chk("abort_done_count", done_cnt, 1);
    chk("abort_error_held", 32'(Error), 1);
    begin_job(32'hB000, 24'd8, 2, 1'b1);
    chk("start_clears_error", 32'(Error), 0);
    wait_idle("post_abort_timeout", 1000);
    chk("post_abort_pops", pop_n, 2);
    chk("post_abort_error", 32'(Error), 0);

    // reset in the middle of a fetch, then a zero-length job
    begin_job(32'hC000, 24'd256, 64, 1'b0);
    wait_addr("rst_wait", 4, 100);
    hold_valid = 1'b1;
    cyc(1);
    rst = 1'b0; #1;
    chk_reset_vals("midrst");
    cyc(2);
    rst = 1'b1; hold_valid = 1'b0;
    cyc(4);
    chk("rst_late_valid", 32'(bus.DataOutEnable), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_no_done", done_cnt, 0);
    ByteLength = 24'd0; StartAddr = 32'hC100;
    Start = 1'b1; cyc(1); Start = 1'b0;
    chk("zero_done", 32'(Done), 1);
    chk("zero_error", 32'(Error), 1);
    chk("zero_memreq", 32'(bus.MemReq), 0);
    cyc(1);
    chk("zero_done_low", 32'(Done), 0);
    chk("zero_idle", 32'(Busy), 0);

    // memory never acks
    mem_on = 1'b0;
    begin_job(32'hD000, 24'd8, 10, 1'b1);
`ifdef AQ_DJPEG_LOADER_WATCHDOG_EN
    begin
      int k = 0;
      while (Busy && k < 300) begin cyc(1); k++; end
      chk("wd_latency", 32'(k >= 95 && k <= 110), 1);
    end
    chk("wd_idle", 32'(Busy), 0);
    chk("wd_done", done_cnt, 1);
    chk("wd_err_at_done", 32'(err_at_done), 1);
    chk("wd_error", 32'(Error), 1);
`else
    cyc(300);
    chk("stall_busy", 32'(Busy), 1);
    chk("stall_no_done", done_cnt, 0);
    Abort = 1'b1; cyc(1); Abort = 1'b0;
    chk("stall_abort_error", 32'(Error), 1);
    cyc(1);
    chk("stall_abort_idle", 32'(Busy), 0);
    chk("stall_done", done_cnt, 1);
`endif
    mem_on = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
